// File: rtl/pong_pkg.sv
// Shared screen geometry, direction bit positions and bounding-box type
// used by the pong game core's collision and movement logic.
package pong_pkg;

    localparam int H_RES   = 640;
    localparam int V_RES   = 480;
    localparam int COORD_W = 32;
    localparam int BBOX_W  = COORD_W + 2;

    localparam int DIR_DOWN  = 0;
    localparam int DIR_RIGHT = 1;
    localparam int DIR_UP    = 2;
    localparam int DIR_LEFT  = 3;

    typedef struct packed {
        logic signed [BBOX_W-1:0] lo_x;
        logic signed [BBOX_W-1:0] hi_x;
        logic signed [BBOX_W-1:0] lo_y;
        logic signed [BBOX_W-1:0] hi_y;
    } bbox_t;

endpackage

// File: rtl/rect_bounds.sv
// Combinational bounding box and wall-clearance flags for one screen object.
module rect_bounds #(
    parameter int H_RES   = pong_pkg::H_RES,
    parameter int V_RES   = pong_pkg::V_RES,
    parameter int COORD_W = pong_pkg::COORD_W
) (
    input  logic signed [COORD_W-1:0] size_x,
    input  logic signed [COORD_W-1:0] size_y,
    input  logic signed [COORD_W-1:0] ini_x,
    input  logic signed [COORD_W-1:0] ini_y,
    input  logic signed [COORD_W-1:0] off_x,
    input  logic signed [COORD_W-1:0] off_y,
    output pong_pkg::bbox_t           box,
    output logic [3:0]                wall_ok
);
    import pong_pkg::*;

    localparam int W2 = COORD_W + 2;
    localparam logic signed [W2-1:0] H_LIM = W2'(H_RES);
    localparam logic signed [W2-1:0] V_LIM = W2'(V_RES);
    localparam logic signed [W2-1:0] ZERO  = '0;

    logic signed [W2-1:0] lo_x, hi_x, lo_y, hi_y;

    always_comb begin
        lo_x = W2'(ini_x) + W2'(off_x);
        hi_x = lo_x + W2'(size_x);
        lo_y = W2'(ini_y) + W2'(off_y);
        hi_y = lo_y + W2'(size_y);

        box.lo_x = BBOX_W'(lo_x);
        box.hi_x = BBOX_W'(hi_x);
        box.lo_y = BBOX_W'(lo_y);
        box.hi_y = BBOX_W'(hi_y);

        // Sitting exactly on a wall counts as blocked in that direction.
        wall_ok            = '0;
        wall_ok[DIR_DOWN]  = hi_y < V_LIM;
        wall_ok[DIR_RIGHT] = hi_x < H_LIM;
        wall_ok[DIR_UP]    = lo_y > ZERO;
        wall_ok[DIR_LEFT]  = lo_x > ZERO;
    end

endmodule

// File: rtl/edge_detect_unit.sv
// Registered wall and ball/paddle contact detector; outputs are the
// free-to-move flags consumed by the movement logic one cycle later.
module edge_detect_unit #(
    parameter int H_RES   = pong_pkg::H_RES,
    parameter int V_RES   = pong_pkg::V_RES,
    parameter int COORD_W = pong_pkg::COORD_W
) (
    input  logic                      pixel_clk,
    input  logic                      reset,
    input  logic signed [COORD_W-1:0] ball_size_x,
    input  logic signed [COORD_W-1:0] ball_size_y,
    input  logic signed [COORD_W-1:0] ball_ini_x,
    input  logic signed [COORD_W-1:0] ball_ini_y,
    input  logic signed [COORD_W-1:0] ball_off_x,
    input  logic signed [COORD_W-1:0] ball_off_y,
    input  logic signed [COORD_W-1:0] paddle_R_size_x,
    input  logic signed [COORD_W-1:0] paddle_R_size_y,
    input  logic signed [COORD_W-1:0] paddle_R_ini_x,
    input  logic signed [COORD_W-1:0] paddle_R_ini_y,
    input  logic signed [COORD_W-1:0] paddle_R_off_x,
    input  logic signed [COORD_W-1:0] paddle_R_off_y,
    input  logic signed [COORD_W-1:0] paddle_L_size_x,
    input  logic signed [COORD_W-1:0] paddle_L_size_y,
    input  logic signed [COORD_W-1:0] paddle_L_ini_x,
    input  logic signed [COORD_W-1:0] paddle_L_ini_y,
    input  logic signed [COORD_W-1:0] paddle_L_off_x,
    input  logic signed [COORD_W-1:0] paddle_L_off_y,
    output logic [3:0]                ball_detect_edge,
    output logic [3:0]                paddle_R_detect_edge,
    output logic [3:0]                paddle_L_detect_edge,
    output logic [7:0]                collision_detect
);
    import pong_pkg::*;

    bbox_t      ball_box, pad_r_box, pad_l_box;
    logic [3:0] ball_wall, pad_r_wall, pad_l_wall;
    logic [3:0] hit_r, hit_l;
    logic [3:0] ball_next;

    rect_bounds #(.H_RES(H_RES), .V_RES(V_RES), .COORD_W(COORD_W)) u_ball (
        .size_x (ball_size_x), .size_y (ball_size_y),
        .ini_x  (ball_ini_x),  .ini_y  (ball_ini_y),
        .off_x  (ball_off_x),  .off_y  (ball_off_y),
        .box    (ball_box),    .wall_ok(ball_wall)
    );

    rect_bounds #(.H_RES(H_RES), .V_RES(V_RES), .COORD_W(COORD_W)) u_pad_r (
        .size_x (paddle_R_size_x), .size_y (paddle_R_size_y),
        .ini_x  (paddle_R_ini_x),  .ini_y  (paddle_R_ini_y),
        .off_x  (paddle_R_off_x),  .off_y  (paddle_R_off_y),
        .box    (pad_r_box),       .wall_ok(pad_r_wall)
    );

    rect_bounds #(.H_RES(H_RES), .V_RES(V_RES), .COORD_W(COORD_W)) u_pad_l (
        .size_x (paddle_L_size_x), .size_y (paddle_L_size_y),
        .ini_x  (paddle_L_ini_x),  .ini_y  (paddle_L_ini_y),
        .off_x  (paddle_L_off_x),  .off_y  (paddle_L_off_y),
        .box    (pad_l_box),       .wall_ok(pad_l_wall)
    );

    // Sides of paddle p that ball b touches; zero unless the boxes overlap.
    function automatic logic [3:0] contact_sides(input bbox_t b, input bbox_t p);
        logic       overlap;
        logic [3:0] sides;
        overlap = ($signed(b.lo_x) < $signed(p.hi_x)) && ($signed(p.lo_x) < $signed(b.hi_x)) &&
                  ($signed(b.lo_y) < $signed(p.hi_y)) && ($signed(p.lo_y) < $signed(b.hi_y));
        sides            = '0;
        sides[DIR_DOWN]  = $signed(b.lo_y) <= $signed(p.lo_y);
        sides[DIR_RIGHT] = $signed(b.lo_x) <= $signed(p.lo_x);
        sides[DIR_UP]    = $signed(b.hi_y) >= $signed(p.hi_y);
        sides[DIR_LEFT]  = $signed(b.hi_x) >= $signed(p.hi_x);
        return overlap ? sides : 4'b0000;
    endfunction

    always_comb begin
        hit_r     = contact_sides(ball_box, pad_r_box);
        hit_l     = contact_sides(ball_box, pad_l_box);
        ball_next = ball_wall & ~hit_r & ~hit_l;
    end

    always_ff @(posedge pixel_clk or posedge reset) begin
        if (reset) begin
            ball_detect_edge     <= '0;
            paddle_R_detect_edge <= '0;
            paddle_L_detect_edge <= '0;
            collision_detect     <= '0;
        end else begin
            ball_detect_edge     <= ball_next;
            paddle_R_detect_edge <= pad_r_wall;
            paddle_L_detect_edge <= pad_l_wall;
            collision_detect     <= {hit_l, hit_r};
        end
    end

endmodule

// File: tb/tb_edge_detect_unit.sv
// Directed-vector bench for edge_detect_unit with hand-computed expectations.
module tb_edge_detect_unit;

    logic               t_clk;
    logic               reset;
    logic signed [31:0] ball_size_x, ball_size_y, ball_ini_x, ball_ini_y, ball_off_x, ball_off_y;
    logic signed [31:0] paddle_R_size_x, paddle_R_size_y, paddle_R_ini_x, paddle_R_ini_y;
    logic signed [31:0] paddle_R_off_x, paddle_R_off_y;
    logic signed [31:0] paddle_L_size_x, paddle_L_size_y, paddle_L_ini_x, paddle_L_ini_y;
    logic signed [31:0] paddle_L_off_x, paddle_L_off_y;
    logic [3:0]         ball_detect_edge, paddle_R_detect_edge, paddle_L_detect_edge;
    logic [7:0]         collision_detect;

    int unsigned n_cmp = 0;
    int unsigned n_bad = 0;

    edge_detect_unit #(.H_RES(640), .V_RES(480), .COORD_W(32)) dut (
        .pixel_clk            (t_clk),
        .reset                (reset),
        .ball_size_x          (ball_size_x),
        .ball_size_y          (ball_size_y),
        .ball_ini_x           (ball_ini_x),
        .ball_ini_y           (ball_ini_y),
        .ball_off_x           (ball_off_x),
        .ball_off_y           (ball_off_y),
        .paddle_R_size_x      (paddle_R_size_x),
        .paddle_R_size_y      (paddle_R_size_y),
        .paddle_R_ini_x       (paddle_R_ini_x),
        .paddle_R_ini_y       (paddle_R_ini_y),
        .paddle_R_off_x       (paddle_R_off_x),
        .paddle_R_off_y       (paddle_R_off_y),
        .paddle_L_size_x      (paddle_L_size_x),
        .paddle_L_size_y      (paddle_L_size_y),
        .paddle_L_ini_x       (paddle_L_ini_x),
        .paddle_L_ini_y       (paddle_L_ini_y),
        .paddle_L_off_x       (paddle_L_off_x),
        .paddle_L_off_y       (paddle_L_off_y),
        .ball_detect_edge     (ball_detect_edge),
        .paddle_R_detect_edge (paddle_R_detect_edge),
        .paddle_L_detect_edge (paddle_L_detect_edge),
        .collision_detect     (collision_detect)
    );

    initial t_clk = 1'b0;
    always #5 t_clk = ~t_clk;

    task automatic check(input string tag, input logic [7:0] obs, input logic [7:0] exp);
        n_cmp++;
        if (obs !== exp) begin
            n_bad++;
            $display("FAIL %s: got %b, want %b", tag, obs, exp);
        end
    endtask

    task automatic check_all(input string tag, input logic [3:0] b, input logic [3:0] r,
                             input logic [3:0] l, input logic [7:0] c);
        check({tag, ".ball"}, {4'b0, ball_detect_edge}, {4'b0, b});
        check({tag, ".padR"}, {4'b0, paddle_R_detect_edge}, {4'b0, r});
        check({tag, ".padL"}, {4'b0, paddle_L_detect_edge}, {4'b0, l});
        check({tag, ".coll"}, collision_detect, c);
    endtask

    // Inputs are changed 1 ns after an edge; this waits for the edge that captures them.
    task automatic step;
        @(posedge t_clk);
        #1;
    endtask

    task automatic set_defaults;
        ball_size_x = 25;      ball_size_y = 25;      ball_ini_x = 269;     ball_ini_y = 189;
        ball_off_x  = 0;       ball_off_y  = 0;
        paddle_R_size_x = 10;  paddle_R_size_y = 150; paddle_R_ini_x = 600; paddle_R_ini_y = 100;
        paddle_R_off_x  = 0;   paddle_R_off_y  = 0;
        paddle_L_size_x = 10;  paddle_L_size_y = 150; paddle_L_ini_x = 40;  paddle_L_ini_y = 189;
        paddle_L_off_x  = 0;   paddle_L_off_y  = 0;
    endtask

    initial begin
        reset = 1'b1;
        set_defaults();
        repeat (3) @(posedge t_clk);
        #1;
        check_all("in_reset", 4'b0000, 4'b0000, 4'b0000, 8'h00);

        reset = 1'b0;
        step();
        check_all("post_reset", 4'b1111, 4'b1111, 4'b1111, 8'h00);

        // Right wall exactly touched (hi_x = 640).
        ball_off_x = 346; step();
        check_all("wall_right", 4'b1101, 4'b1111, 4'b1111, 8'h00);

        // Left wall exactly touched (lo_x = 0).
        ball_off_x = -269; step();
        check_all("wall_left", 4'b0111, 4'b1111, 4'b1111, 8'h00);

        // Bottom wall touched (hi_y = 480) and top wall overshot (lo_y = -111).
        ball_off_x = 0; ball_off_y = 266; step();
        check("wall_bottom", {4'b0, ball_detect_edge}, 8'h0E);
        ball_off_y = -300; step();
        check("past_top", {4'b0, ball_detect_edge}, 8'h0B);

        // Ball 579..604 against R paddle's left face.
        ball_off_y = 0; ball_off_x = 310; step();
        check_all("hit_R_left", 4'b1101, 4'b1111, 4'b1111, 8'h02);

        // Ball 34..59 straddles L paddle 40..50 with tops aligned: top, left and right faces.
        ball_off_x = -235; step();
        check_all("hit_L_straddle", 4'b0100, 4'b1111, 4'b1111, 8'hB0);

        // Ball 41..66, rows 190..215: touches only L paddle's right face.
        ball_off_x = -228; ball_off_y = 1; step();
        check_all("hit_L_right", 4'b0111, 4'b1111, 4'b1111, 8'h80);

        // Paddle walls.
        ball_off_x = 0; ball_off_y = 0;
        paddle_R_off_y = -100; paddle_L_off_y = 291; step();
        check_all("pad_walls", 4'b1111, 4'b1011, 4'b1110, 8'h00);

        // One-cycle latency on ball right flag, then asynchronous reset.
        paddle_R_off_y = 0; paddle_L_off_y = 0; step();
        check("lat_base", {4'b0, ball_detect_edge}, 8'h0F);
        ball_off_x = 346; #2;
        check("lat_before_edge", {4'b0, ball_detect_edge}, 8'h0F);
        step();
        check("lat_after_edge", {4'b0, ball_detect_edge}, 8'h0D);
        #2 reset = 1'b1; #1;
        check_all("async_reset", 4'b0000, 4'b0000, 4'b0000, 8'h00);
        step();
        check_all("reset_hold", 4'b0000, 4'b0000, 4'b0000, 8'h00);

        reset = 1'b0; step();
        check_all("rerelease", 4'b1101, 4'b1111, 4'b1111, 8'h00);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
